rice_core_trap_ctrl: RTL and testbench
======================================

# rice_core_trap_ctrl

Multi-lane retire and trap controller for the rice core, sitting between the EX/retire stage and the fetch redirect path. It accepts up to RETIRE_WIDTH in-order retiring instructions per cycle, commits exceptions and MRET, and holds the machine-mode trap CSRs and privilege level. It also maintains the cycle and retired-instruction counters and drives a registered pipeline flush/redirect. It generalises the single-lane EX-to-environment handshake to N lanes with architectural state.

## Interface
- XLEN, 32: data/PC width; 32 or 64.
- RETIRE_WIDTH, 2: retire lanes; 1..4; lane 0 is oldest.
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_retire_valid  in  RETIRE_WIDTH  lane carries a retiring instruction.
- i_retire_pc  in  RETIRE_WIDTH×XLEN  per-lane PC.
- i_retire_exception  in  RETIRE_WIDTH  lane raised an exception.
- i_retire_cause  in  RETIRE_WIDTH×4  exception code (mcause[3:0]).
- i_retire_tval  in  RETIRE_WIDTH×XLEN  trap value.
- i_retire_mret  in  RETIRE_WIDTH  lane is MRET.
- i_csr_valid  in  1  CSR access this cycle.
- i_csr_write  in  1  access writes i_csr_wdata.
- i_csr_addr  in  12  CSR address.
- i_csr_wdata  in  XLEN  write data.
- o_csr_rdata  out  XLEN  read data (combinational).
- o_csr_illegal  out  1  unsupported address (combinational).
- o_privilege_level  out  2  current level (3=M, 0=U).
- o_trap_pc  out  XLEN  mtvec base.
- o_return_pc  out  XLEN  mepc.
- o_flush  out  1  registered redirect pulse.
- o_flush_pc  out  XLEN  redirect target, valid with o_flush.

## Operation
- Lane k is effective when valid and no lower lane is valid with exception or mret. Lanes above the first exception/mret lane are discarded.
- Exception on effective lane k:
  - mepc←pc[k] with [1:0]=0, mcause←{0,cause}, mtval←tval.
  - MPIE←MIE, MIE←0, MPP←priv, priv←M.
  - Flush to mtvec base.
- Exception and mret on the same lane are treated as an exception.
- MRET on effective lane k:
  - priv←MPP, MIE←MPIE, MPIE←1, MPP←U (M when user mode is compiled out).
  - Flush to mepc.
- minstret increments by the count of effective lanes, excluding the faulting lane and including the MRET lane. mcycle increments every cycle. Both counters are 64-bit and wrap to 0.
- CSR map:
  - mstatus 0x300: only MIE[3], MPIE[7], MPP[12:11] are writable; all other bits read 0.
  - mtvec 0x305: direct mode only; writes force [1:0]=0.
  - mepc 0x341: writes force [1:0]=0.
  - mcause 0x342, mtval 0x343.
  - mcycle 0xB00, minstret 0xB02.
  - mcycleh 0xB80 and minstreth 0xB82 exist only when XLEN=32.
  - Any other address: o_csr_illegal=1, rdata=0, write ignored.
- Write/update conflicts:
  - A CSR write in the same cycle as a trap or MRET commit is dropped.
  - A CSR write to a counter in the same cycle as an increment: the write wins.
  - MPP writes of 1 or 2 are legalised to 0 (U).

## Timing
- Reset (synchronous, i_rst_n=0 at posedge) sets:
  - priv=3, mstatus=0, mtvec=0, mepc=0, mcause=0, mtval=0, mcycle=0, minstret=0.
  - o_flush=0, o_flush_pc=0.
- CSR read: 0-cycle latency. Reads return the pre-edge value; writes are visible the next cycle.
- Trap/MRET commit updates state at the edge. o_flush=1 for exactly one cycle after; o_flush_pc holds the new target that cycle.
- o_trap_pc, o_return_pc, o_privilege_level are combinational from registers.
- The retire source must not present valid lanes in the cycle o_flush=1. Any lanes presented then are ignored and not counted.
- Reset asserted in the same cycle as a commit: reset wins and no flush is issued.

## Configuration
- RICE_CORE_USER_MODE_EN defined:
  - U-mode is supported; MPP is writable (0 or 3).
  - MRET to MPP=0 drops priv to 0.
- RICE_CORE_USER_MODE_EN undefined:
  - priv is fixed at 3; MPP is read-only 3.
  - MRET leaves priv=3.

## Test plan
- Reset, then 4 cycles of 2 valid clean lanes: minstret=8 and mcycle=4 read back; o_flush stays 0.
- Set mtvec=0x100. Lane0 clean at pc 0x40, lane1 exception cause 2, tval 0xDEAD, pc 0x44. Required: mepc=0x44, mcause=2, mtval=0xDEAD, minstret+1, priv=3; next cycle o_flush=1 with o_flush_pc=0x100.
- Lane0 mret, lane1 valid: lane1 discarded, minstret+1; next cycle o_flush_pc=mepc. With USER_MODE_EN and MPP=0: priv=0, MIE=old MPIE, MPIE=1.
- Exception on lane0 with a CSR write to mepc in the same cycle: the write is dropped and mepc=lane0 pc.
- XLEN=32: write minstret=0xFFFFFFFF, then retire 1: minstret=0 and minstreth=1. Access 0x7C0: o_csr_illegal=1, rdata=0.

Source files
------------

// File: rtl/rice_core_trap_ctrl.sv
// Multi-lane retire/trap controller: machine-mode trap CSRs, privilege, counters, flush.
// Optional U-mode support is enabled by defining RICE_CORE_USER_MODE_EN.
module rice_core_trap_ctrl #(
    parameter int XLEN         = 32,
    parameter int RETIRE_WIDTH = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [RETIRE_WIDTH-1:0]      i_retire_valid,
    input  logic [RETIRE_WIDTH*XLEN-1:0] i_retire_pc,
    input  logic [RETIRE_WIDTH-1:0]      i_retire_exception,
    input  logic [RETIRE_WIDTH*4-1:0]    i_retire_cause,
    input  logic [RETIRE_WIDTH*XLEN-1:0] i_retire_tval,
    input  logic [RETIRE_WIDTH-1:0]      i_retire_mret,
    input  logic                         i_csr_valid,
    input  logic                         i_csr_write,
    input  logic [11:0]                  i_csr_addr,
    input  logic [XLEN-1:0]              i_csr_wdata,
    output logic [XLEN-1:0]              o_csr_rdata,
    output logic                         o_csr_illegal,
    output logic [1:0]                   o_privilege_level,
    output logic [XLEN-1:0]              o_trap_pc,
    output logic [XLEN-1:0]              o_return_pc,
    output logic                         o_flush,
    output logic [XLEN-1:0]              o_flush_pc
);
    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [1:0]  PRIV_M      = 2'b11;
    localparam logic [1:0]  PRIV_U      = 2'b00;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
`ifdef RICE_CORE_USER_MODE_EN
    localparam logic [1:0]  MPP_RST     = PRIV_U;
`else
    localparam logic [1:0]  MPP_RST     = PRIV_M;
`endif

    logic [1:0]      priv_q, priv_d, mpp_q, mpp_d;
    logic            mie_q, mie_d, mpie_q, mpie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d, mtval_q, mtval_d;
    logic [63:0]     mcycle_q, mcycle_d, minstret_q, minstret_d;
    logic            flush_q, flush_d;
    logic [XLEN-1:0] flush_pc_q, flush_pc_d;

    logic            trap_hit, mret_hit, blocked, csr_we;
    logic [2:0]      eff_cnt;
    logic [XLEN-1:0] sel_pc, sel_tval, mstatus_rd;
    logic [3:0]      sel_cause;

    // Oldest-first scan; lanes presented during the flush cycle are ignored.
    always_comb begin
        trap_hit  = 1'b0;
        mret_hit  = 1'b0;
        blocked   = 1'b0;
        eff_cnt   = 3'd0;
        sel_pc    = '0;
        sel_tval  = '0;
        sel_cause = 4'd0;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            if (!blocked && !flush_q && i_retire_valid[k]) begin
                if (i_retire_exception[k]) begin
                    trap_hit  = 1'b1;
                    blocked   = 1'b1;
                    sel_pc    = i_retire_pc[k*XLEN +: XLEN];
                    sel_tval  = i_retire_tval[k*XLEN +: XLEN];
                    sel_cause = i_retire_cause[k*4 +: 4];
                end else if (i_retire_mret[k]) begin
                    mret_hit = 1'b1;
                    blocked  = 1'b1;
                    eff_cnt  = eff_cnt + 3'd1;
                end else begin
                    eff_cnt = eff_cnt + 3'd1;
                end
            end
        end
    end

    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[3]     = mie_q;
        mstatus_rd[7]     = mpie_q;
        mstatus_rd[12:11] = mpp_q;
        o_csr_rdata       = '0;
        o_csr_illegal     = 1'b0;
        case (i_csr_addr)
            A_MSTATUS:   o_csr_rdata = mstatus_rd;
            A_MTVEC:     o_csr_rdata = mtvec_q;
            A_MEPC:      o_csr_rdata = mepc_q;
            A_MCAUSE:    o_csr_rdata = mcause_q;
            A_MTVAL:     o_csr_rdata = mtval_q;
            A_MCYCLE:    o_csr_rdata = XLEN'(mcycle_q);
            A_MINSTRET:  o_csr_rdata = XLEN'(minstret_q);
            A_MCYCLEH: begin
                if (XLEN == 32) o_csr_rdata = XLEN'(mcycle_q[63:32]);
                else            o_csr_illegal = 1'b1;
            end
            A_MINSTRETH: begin
                if (XLEN == 32) o_csr_rdata = XLEN'(minstret_q[63:32]);
                else            o_csr_illegal = 1'b1;
            end
            default:     o_csr_illegal = 1'b1;
        endcase
    end

    always_comb begin
        csr_we     = i_csr_valid && i_csr_write && !o_csr_illegal && !trap_hit && !mret_hit;
        priv_d     = priv_q;
        mpp_d      = mpp_q;
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + 64'(eff_cnt);
        flush_d    = trap_hit || mret_hit;
        flush_pc_d = flush_pc_q;

        // Counter writes replace only the addressed half, on top of the increment.
        if (csr_we) begin
            case (i_csr_addr)
                A_MSTATUS: begin
                    mie_d  = i_csr_wdata[3];
                    mpie_d = i_csr_wdata[7];
`ifdef RICE_CORE_USER_MODE_EN
                    mpp_d  = (i_csr_wdata[12:11] == PRIV_M) ? PRIV_M : PRIV_U;
`endif
                end
                A_MTVEC:  mtvec_d  = i_csr_wdata & ALIGN_MASK;
                A_MEPC:   mepc_d   = i_csr_wdata & ALIGN_MASK;
                A_MCAUSE: mcause_d = i_csr_wdata;
                A_MTVAL:  mtval_d  = i_csr_wdata;
                A_MCYCLE: begin
                    if (XLEN == 32) mcycle_d[31:0] = i_csr_wdata[31:0];
                    else            mcycle_d       = 64'(i_csr_wdata);
                end
                A_MINSTRET: begin
                    if (XLEN == 32) minstret_d[31:0] = i_csr_wdata[31:0];
                    else            minstret_d       = 64'(i_csr_wdata);
                end
                A_MCYCLEH:   mcycle_d[63:32]   = i_csr_wdata[31:0];
                A_MINSTRETH: minstret_d[63:32] = i_csr_wdata[31:0];
                default: ;
            endcase
        end

        if (trap_hit) begin
            mepc_d     = sel_pc & ALIGN_MASK;
            mcause_d   = XLEN'(sel_cause);
            mtval_d    = sel_tval;
            mpie_d     = mie_q;
            mie_d      = 1'b0;
            mpp_d      = priv_q;
            priv_d     = PRIV_M;
            flush_pc_d = mtvec_q;
        end else if (mret_hit) begin
            priv_d     = mpp_q;
            mie_d      = mpie_q;
            mpie_d     = 1'b1;
            mpp_d      = MPP_RST;
            flush_pc_d = mepc_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            priv_q     <= PRIV_M;
            mpp_q      <= MPP_RST;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else begin
            priv_q     <= priv_d;
            mpp_q      <= mpp_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            flush_q    <= flush_d;
            flush_pc_q <= flush_pc_d;
        end
    end

    assign o_privilege_level = priv_q;
    assign o_trap_pc         = mtvec_q;
    assign o_return_pc       = mepc_q;
    assign o_flush           = flush_q;
    assign o_flush_pc        = flush_pc_q;
endmodule

// File: tb/tb_rice_core_trap_ctrl.sv
// Directed bench for rice_core_trap_ctrl (XLEN=32, two retire lanes).
module tb_rice_core_trap_ctrl;
    localparam int XLEN = 32;
    localparam int RW   = 2;
`ifdef RICE_CORE_USER_MODE_EN
    localparam logic [31:0] MS_MPP_RST = 32'h0000_0000;
`else
    localparam logic [31:0] MS_MPP_RST = 32'h0000_1800;
`endif

    logic clk = 1'b0;
    always #50 clk = ~clk;

    logic               rst_n;
    logic [RW-1:0]      rv, rexc, rmret;
    logic [RW*XLEN-1:0] rpc, rtval;
    logic [RW*4-1:0]    rcause;
    logic               csr_valid, csr_write;
    logic [11:0]        csr_addr;
    logic [XLEN-1:0]    csr_wdata, csr_rdata, trap_pc, return_pc, flush_pc;
    logic               csr_illegal, flush;
    logic [1:0]         priv;

    int n_assert = 0;
    int n_fail   = 0;

    rice_core_trap_ctrl #(.XLEN(XLEN), .RETIRE_WIDTH(RW)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_retire_valid     (rv),
        .i_retire_pc        (rpc),
        .i_retire_exception (rexc),
        .i_retire_cause     (rcause),
        .i_retire_tval      (rtval),
        .i_retire_mret      (rmret),
        .i_csr_valid        (csr_valid),
        .i_csr_write        (csr_write),
        .i_csr_addr         (csr_addr),
        .i_csr_wdata        (csr_wdata),
        .o_csr_rdata        (csr_rdata),
        .o_csr_illegal      (csr_illegal),
        .o_privilege_level  (priv),
        .o_trap_pc          (trap_pc),
        .o_return_pc        (return_pc),
        .o_flush            (flush),
        .o_flush_pc         (flush_pc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rv = '0; rexc = '0; rmret = '0; rpc = '0; rtval = '0; rcause = '0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
        csr_valid = 1'b1; csr_write = 1'b0; csr_addr = a;
        #1;
        chk(tag, 64'(csr_rdata), 64'(exp));
        csr_valid = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_valid = 1'b1; csr_write = 1'b1; csr_addr = a; csr_wdata = d;
        tick();
        csr_valid = 1'b0; csr_write = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; csr_valid = 1'b0; csr_write = 1'b0; csr_addr = '0; csr_wdata = '0;
        idle();
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_priv", 64'(priv), 64'd3);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_flush_pc", 64'(flush_pc), 64'd0);
        chk("rst_return_pc", 64'(return_pc), 64'd0);
        rd(12'h300, MS_MPP_RST, "rst_mstatus");
        rd(12'hB00, 32'd0, "rst_mcycle");

        // Four cycles of two clean lanes
        rv = 2'b11; rpc = {32'h0000_0014, 32'h0000_0010};
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("clean_flush", 64'(flush), 64'd0);
        end
        idle();
        rd(12'hB02, 32'd8, "clean_minstret");
        rd(12'hB00, 32'd4, "clean_mcycle");
        rd(12'hB82, 32'd0, "clean_minstreth");

        wr(12'h305, 32'h0000_0103);
        rd(12'h305, 32'h0000_0100, "mtvec_align");
        chk("trap_pc", 64'(trap_pc), 64'h100);
        wr(12'h300, 32'h0000_0008);
        rd(12'h300, MS_MPP_RST | 32'h8, "mstatus_mie");

        // Lane1 exception, lane0 clean
        rv = 2'b11; rexc = 2'b10; rpc = {32'h0000_0046, 32'h0000_0040};
        rcause = {4'd2, 4'd0}; rtval = {32'h0000_DEAD, 32'h0};
        tick(); idle();
        chk("exc_flush", 64'(flush), 64'd1);
        chk("exc_flush_pc", 64'(flush_pc), 64'h100);
        chk("exc_mepc", 64'(return_pc), 64'h44);
        chk("exc_priv", 64'(priv), 64'd3);
        rd(12'h342, 32'd2, "exc_mcause");
        rd(12'h343, 32'h0000_DEAD, "exc_mtval");
        rd(12'hB02, 32'd9, "exc_minstret");
        rd(12'h300, 32'h0000_1880, "exc_mstatus");
        tick();
        chk("exc_flush_once", 64'(flush), 64'd0);

        // Lane0 MRET, lane1 discarded
        rv = 2'b11; rmret = 2'b01; rpc = {32'h0000_0054, 32'h0000_0050};
        tick(); idle();
        chk("mret_flush", 64'(flush), 64'd1);
        chk("mret_flush_pc", 64'(flush_pc), 64'h44);
        chk("mret_priv", 64'(priv), 64'd3);
        rd(12'hB02, 32'd10, "mret_minstret");
`ifdef RICE_CORE_USER_MODE_EN
        rd(12'h300, 32'h0000_0088, "mret_mstatus");
`else
        rd(12'h300, 32'h0000_1888, "mret_mstatus");
`endif

        // Lanes presented during the flush cycle are ignored
        rv = 2'b01; rexc = 2'b01; rpc = {32'h0, 32'h0000_0060}; rcause = {4'd0, 4'd7};
        tick(); idle();
        chk("ign_flush", 64'(flush), 64'd0);
        chk("ign_mepc", 64'(return_pc), 64'h44);
        rd(12'hB02, 32'd10, "ign_minstret");
        rd(12'h342, 32'd2, "ign_mcause");

        // Exception with a concurrent mepc write: write dropped
        rv = 2'b01; rexc = 2'b01; rpc = {32'h0, 32'h0000_0080}; rcause = {4'd0, 4'd5};
        wr(12'h341, 32'h0000_1234);
        idle();
        chk("conf_mepc", 64'(return_pc), 64'h80);
        chk("conf_flush", 64'(flush), 64'd1);
        chk("conf_flush_pc", 64'(flush_pc), 64'h100);
        rd(12'h342, 32'd5, "conf_mcause");
        rd(12'hB02, 32'd10, "conf_minstret");
        rd(12'h300, 32'h0000_1880, "conf_mstatus");
        tick();

        // Counter write wins over a concurrent increment, then wrap into the high half
        rv = 2'b11; rpc = {32'h0000_00A4, 32'h0000_00A0};
        wr(12'hB02, 32'hFFFF_FFFF);
        idle();
        rd(12'hB02, 32'hFFFF_FFFF, "ww_minstret");
        rd(12'hB82, 32'd0, "ww_minstreth");
        rv = 2'b01; rpc = {32'h0, 32'h0000_00B0};
        tick(); idle();
        rd(12'hB02, 32'd0, "wrap_minstret");
        rd(12'hB82, 32'd1, "wrap_minstreth");
        wr(12'hB00, 32'd5);
        rd(12'hB00, 32'd5, "mcycle_write");

        csr_valid = 1'b1; csr_addr = 12'h7C0;
        #1;
        chk("illegal_flag", 64'(csr_illegal), 64'd1);
        chk("illegal_rdata", 64'(csr_rdata), 64'd0);
        csr_addr = 12'h300;
        #1;
        chk("legal_flag", 64'(csr_illegal), 64'd0);
        csr_valid = 1'b0;

        // Reset coinciding with a commit
        rst_n = 1'b0;
        rv = 2'b01; rexc = 2'b01; rpc = {32'h0, 32'h0000_0090}; rcause = {4'd0, 4'd3};
        tick();
        rst_n = 1'b1; idle();
        chk("rstc_flush", 64'(flush), 64'd0);
        chk("rstc_mepc", 64'(return_pc), 64'd0);
        chk("rstc_priv", 64'(priv), 64'd3);
        rd(12'hB02, 32'd0, "rstc_minstret");
        tick();
        chk("rstc_flush_next", 64'(flush), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
